instruction_decode_pipe: RTL and testbench

INSTRUCTION_DECODE_PIPE -- requirements
Module: instruction_decode_pipe

---
 rtl/instruction_decode_pipe.sv | 164 ++++++++++++++++
 tb/tb_instruction_decode_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_pipe.sv
// Single-cycle instruction decoder with an output register and one skid register.
// Define ID_LOADUSE_STALL_EN to insert a one-cycle bubble on LW load-use hazards.
module instruction_decode_pipe #(
    parameter int INST_W = 16,
    parameter int OPC_W  = 3,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                            sysclk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [INST_W-1:0]               in_inst,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            registerwrite,
    output logic [1:0]                      aluop,
    output logic                            alusrc,
    output logic                            memw,
    output logic                            mem2reg,
    output logic [REG_W-1:0]                rd,
    output logic [REG_W-1:0]                rs,
    output logic [REG_W-1:0]                rt,
    output logic [INST_W-OPC_W-2*REG_W-1:0] imm,
    output logic                            illegal,
    output logic [CNT_W-1:0]                dec_count
);

    localparam int IMM_W = INST_W - OPC_W - 2 * REG_W;
    localparam int BUN_W = 7 + 3 * REG_W + IMM_W;
    localparam logic [OPC_W-1:0] OPC_HI = ~OPC_W'(7);

    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] dec_rd, dec_rs, dec_rt;
    logic [IMM_W-1:0] dec_imm;
    logic             dec_ill;
    logic [5:0]       dec_ctrl;
    logic [BUN_W-1:0] dec_bun;

    logic             rdy_en_q;
    logic             out_valid_q, out_valid_d;
    logic [BUN_W-1:0] out_bun_q, out_bun_d;
    logic             skid_valid_q, skid_valid_d;
    logic [BUN_W-1:0] skid_bun_q, skid_bun_d;
    logic [CNT_W-1:0] dec_count_q, dec_count_d;
    logic             in_xfer;

    always_comb begin
        opc      = in_inst[INST_W-1 -: OPC_W];
        dec_rd   = in_inst[INST_W-OPC_W-1 -: REG_W];
        dec_rs   = in_inst[INST_W-OPC_W-REG_W-1 -: REG_W];
        dec_imm  = in_inst[IMM_W-1:0];
        dec_rt   = dec_imm[IMM_W-1 -: REG_W];
        dec_ill  = (opc & OPC_HI) != '0;
        // {registerwrite, aluop, alusrc, memw, mem2reg}
        dec_ctrl = 6'b0;
        case (opc[2:0])
            3'b000:  dec_ctrl = 6'b0_00_000;
            3'b001:  dec_ctrl = 6'b1_01_000;
            3'b010:  dec_ctrl = 6'b1_10_000;
            3'b011:  dec_ctrl = 6'b1_11_000;
            3'b100:  dec_ctrl = 6'b1_00_000;
            3'b101:  dec_ctrl = 6'b1_00_100;
            3'b110:  dec_ctrl = 6'b1_00_101;
            default: dec_ctrl = 6'b0_00_110;
        endcase
        if (dec_ill) begin
            dec_ctrl = 6'b0;
        end
        dec_bun = {dec_ctrl, dec_ill, dec_rd, dec_rs, dec_rt, dec_imm};
    end

`ifdef ID_LOADUSE_STALL_EN
    logic             bubble_q, bubble_d;
    logic             lw_pend_q, lw_pend_d;
    logic [REG_W-1:0] lw_rd_q, lw_rd_d;
    logic             reads_rs, reads_rt, stall;

    always_comb begin
        reads_rs  = !dec_ill && (opc[2:0] != 3'b000) && (dec_rs == lw_rd_q);
        reads_rt  = !dec_ill && (opc[2:0] inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b111})
                    && (dec_rt == lw_rd_q);
        stall     = in_valid && lw_pend_q && !bubble_q && (reads_rs || reads_rt);
        in_ready  = rdy_en_q && !skid_valid_q && !stall;
        in_xfer   = in_valid && in_ready;
        bubble_d  = stall;
        lw_pend_d = lw_pend_q;
        lw_rd_d   = lw_rd_q;
        if (in_xfer) begin
            lw_pend_d = !dec_ill && (opc[2:0] == 3'b110) && (dec_rd != '0);
            lw_rd_d   = dec_rd;
        end else if (bubble_q) begin
            // The bubble has given the load its extra cycle; the hazard is resolved.
            lw_pend_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q  <= 1'b0;
            lw_pend_q <= 1'b0;
            lw_rd_q   <= '0;
        end else begin
            bubble_q  <= bubble_d;
            lw_pend_q <= lw_pend_d;
            lw_rd_q   <= lw_rd_d;
        end
    end
`else
    always_comb begin
        in_ready = rdy_en_q && !skid_valid_q;
        in_xfer  = in_valid && in_ready;
    end
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_bun_d    = out_bun_q;
        skid_valid_d = skid_valid_q;
        skid_bun_d   = skid_bun_q;
        dec_count_d  = dec_count_q;
        if (in_xfer) begin
            dec_count_d = dec_count_q + CNT_W'(1);
        end
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_bun_d    = skid_bun_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_bun_d   = dec_bun;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_bun_d   = dec_bun;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bun_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_bun_q   <= '0;
            dec_count_q  <= '0;
        end else begin
            rdy_en_q     <= 1'b1;
            out_valid_q  <= out_valid_d;
            out_bun_q    <= out_bun_d;
            skid_valid_q <= skid_valid_d;
            skid_bun_q   <= skid_bun_d;
            dec_count_q  <= dec_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dec_count = dec_count_q;
    assign {registerwrite, aluop, alusrc, memw, mem2reg, illegal, rd, rs, rt, imm} = out_bun_q;

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Scoreboard bench for instruction_decode_pipe: default instance plus an OPC_W=4 / CNT_W=2 instance.
module tb_instruction_decode_pipe;

    typedef struct packed {
        logic       rw;
        logic [1:0] aluop;
        logic       alusrc;
        logic       memw;
        logic       mem2reg;
        logic       ill;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [6:0] imm;
    } exp_t;

    logic        sysclk = 0;
    logic        rst_n  = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          rst_cnt = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    logic        in_valid = 0, out_ready = 1;
    logic [15:0] in_inst = 0;
    logic        in_ready, out_valid, registerwrite, alusrc, memw, mem2reg, illegal;
    logic [1:0]  aluop;
    logic [2:0]  rd, rs, rt;
    logic [6:0]  imm;
    logic [15:0] dec_count;

    logic        in_valid_b = 0, out_ready_b = 1;
    logic [15:0] in_inst_b = 0;
    logic        in_ready_b, out_valid_b, registerwrite_b, alusrc_b, memw_b, mem2reg_b, illegal_b;
    logic [1:0]  aluop_b;
    logic [2:0]  rd_b, rs_b, rt_b;
    logic [5:0]  imm_b;
    logic [1:0]  dec_count_b;

    instruction_decode_pipe dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .registerwrite(registerwrite), .aluop(aluop), .alusrc(alusrc), .memw(memw),
        .mem2reg(mem2reg), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .illegal(illegal),
        .dec_count(dec_count)
    );

    instruction_decode_pipe #(.INST_W(16), .OPC_W(4), .REG_W(3), .CNT_W(2)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .in_valid(in_valid_b), .in_inst(in_inst_b),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .registerwrite(registerwrite_b), .aluop(aluop_b), .alusrc(alusrc_b), .memw(memw_b),
        .mem2reg(mem2reg_b), .rd(rd_b), .rs(rs_b), .rt(rt_b), .imm(imm_b), .illegal(illegal_b),
        .dec_count(dec_count_b)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ctrl = {registerwrite, aluop, alusrc, memw, mem2reg, illegal}, hand-written per vector
    function automatic exp_t mk_exp(input logic [15:0] inst, input int opc_w, input logic [6:0] ctrl);
        exp_t e;
        {e.rw, e.aluop, e.alusrc, e.memw, e.mem2reg, e.ill} = ctrl;
        if (opc_w == 3) begin
            e.rd  = inst[12:10];
            e.rs  = inst[9:7];
            e.imm = inst[6:0];
            e.rt  = inst[6:4];
        end else begin
            e.rd  = inst[11:9];
            e.rs  = inst[8:6];
            e.imm = {1'b0, inst[5:0]};
            e.rt  = inst[5:3];
        end
        return e;
    endfunction

    exp_t held_val;
    logic held_vld = 0;
    bit   held_flag = 0;
    int   held_rst = 0;

    always @(negedge sysclk) begin
        exp_t got;
        got = {registerwrite, aluop, alusrc, memw, mem2reg, illegal, rd, rs, rt, imm};
        if (held_flag && held_rst == rst_cnt) begin
            chk("hold_bundle_stable", 32'(got), 32'(held_val));
            chk("hold_valid_stable", 32'(out_valid), 32'(held_vld));
        end
        held_flag = 0;
        if (rst_n && out_valid && !out_ready) begin
            held_flag = 1;
            held_val  = got;
            held_vld  = out_valid;
            held_rst  = rst_cnt;
        end
        if (rst_n && out_valid && out_ready) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_a_unexpected: got bundle %0h with empty scoreboard", got);
            end else begin
                chk("out_a_bundle", 32'(got), 32'(q_a.pop_front()));
            end
        end
    end

    always @(negedge sysclk) begin
        exp_t got;
        got = {registerwrite_b, aluop_b, alusrc_b, memw_b, mem2reg_b, illegal_b,
               rd_b, rs_b, rt_b, {1'b0, imm_b}};
        if (rst_n && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_b_unexpected: got bundle %0h with empty scoreboard", got);
            end else begin
                chk("out_b_bundle", 32'(got), 32'(q_b.pop_front()));
            end
        end
    end

    task automatic send_a(input logic [15:0] inst, input logic [6:0] ctrl, output int acc_cyc);
        bit done = 0;
        in_valid = 1;
        in_inst  = inst;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge sysclk);
            if (in_ready) begin
                q_a.push_back(mk_exp(inst, 3, ctrl));
                done = 1;
            end
            @(posedge sysclk);
            #1;
        end
        acc_cyc  = cyc;
        in_valid = 0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_a_timeout: inst %0h not accepted, required acceptance within 20 cycles", inst);
        end
    endtask

    task automatic send_b(input logic [15:0] inst, input logic [6:0] ctrl);
        bit done = 0;
        in_valid_b = 1;
        in_inst_b  = inst;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge sysclk);
            if (in_ready_b) begin
                q_b.push_back(mk_exp(inst, 4, ctrl));
                done = 1;
            end
            @(posedge sysclk);
            #1;
        end
        in_valid_b = 0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_b_timeout: inst %0h not accepted, required acceptance within 20 cycles", inst);
        end
    endtask

    task automatic do_reset();
        in_valid   = 0;
        in_valid_b = 0;
        rst_n      = 0;
        rst_cnt++;
        q_a.delete();
        q_b.delete();
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_dec_count", 32'(dec_count), 0);
        chk("rst_illegal_b", 32'(illegal_b), 0);
        @(negedge sysclk);
        rst_n = 1;
        @(posedge sysclk);
        #1;
        chk("ready_after_rst", 32'(in_ready), 1);
    endtask

    int c0, c1, c2, c3;
    logic [1:0] cnt_seq [5];

    initial begin
        cnt_seq[0] = 2'd1; cnt_seq[1] = 2'd2; cnt_seq[2] = 2'd3; cnt_seq[3] = 2'd0; cnt_seq[4] = 2'd1;

        // ADD after reset, 1-cycle latency
        do_reset();
        out_ready = 1;
        send_a(16'h8000, 7'b1000000, c0);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_registerwrite", 32'(registerwrite), 1);
        chk("add_aluop", 32'(aluop), 0);
        chk("add_alusrc", 32'(alusrc), 0);
        chk("add_dec_count", 32'(dec_count), 1);

        // ADD, ADDI, LW, SW back-to-back
        do_reset();
        send_a(16'h8530, 7'b1000000, c0);
        send_a(16'hAC8F, 7'b1001000, c1);
        send_a(16'hC885, 7'b1001010, c2);
        send_a(16'hE230, 7'b0001100, c3);
        chk("b2b_gap1", 32'(c1 - c0), 1);
        chk("b2b_gap2", 32'(c2 - c1), 1);
        chk("b2b_gap3", 32'(c3 - c2), 1);
        chk("b2b_dec_count", 32'(dec_count), 4);
        repeat (2) @(posedge sysclk);
        #1;

        // backpressure: two accepted, third blocked, outputs frozen
        do_reset();
        out_ready = 0;
        send_a(16'h7755, 7'b1110000, c0);
        send_a(16'h3C0F, 7'b1010000, c1);
        in_valid = 1;
        in_inst  = 16'h44F0;
        repeat (3) begin
            @(negedge sysclk);
            chk("bp_in_ready_low", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        @(posedge sysclk);
        #1;
        chk("bp_dec_count", 32'(dec_count), 2);
        out_ready = 1;
        send_a(16'h44F0, 7'b1100000, c2);
        chk("bp_dec_count_after", 32'(dec_count), 3);
        repeat (3) @(posedge sysclk);
        #1;

        // load-use: LW rd=3 then ADD rs=3
        do_reset();
        send_a(16'hCC00, 7'b1001010, c0);
        send_a(16'h8580, 7'b1000000, c1);
`ifdef ID_LOADUSE_STALL_EN
        chk("loaduse_gap", 32'(c1 - c0), 2);
        chk("loaduse_dec_count", 32'(dec_count), 2);
`else
        chk("loaduse_gap", 32'(c1 - c0), 1);
        chk("loaduse_dec_count", 32'(dec_count), 2);
`endif
        repeat (2) @(posedge sysclk);
        #1;

        // OPC_W=4 instance: illegal opcodes and 2-bit counter wrap
        do_reset();
        send_b(16'h8000, 7'b0000001);
        chk("b_out_valid", 32'(out_valid_b), 1);
        chk("b_illegal", 32'(illegal_b), 1);
        chk("b_ctrl_zero", 32'({registerwrite_b, aluop_b, alusrc_b, memw_b, mem2reg_b}), 0);
        chk("b_dec_count_0", 32'(dec_count_b), 32'(cnt_seq[0]));
        send_b(16'h2000, 7'b1100000);
        chk("b_dec_count_1", 32'(dec_count_b), 32'(cnt_seq[1]));
        send_b(16'h1000, 7'b1010000);
        chk("b_dec_count_2", 32'(dec_count_b), 32'(cnt_seq[2]));
        send_b(16'h7000, 7'b0001100);
        chk("b_dec_count_3", 32'(dec_count_b), 32'(cnt_seq[3]));
        send_b(16'hF000, 7'b0000001);
        chk("b_dec_count_4", 32'(dec_count_b), 32'(cnt_seq[4]));
        repeat (2) @(posedge sysclk);
        #1;

        // reset pulse between edges with both registers full
        out_ready = 0;
        send_a(16'h8530, 7'b1000000, c0);
        send_a(16'hAC8F, 7'b1001000, c1);
        chk("midrst_pre_valid", 32'(out_valid), 1);
        #1;
        rst_n = 0;
        rst_cnt++;
        q_a.delete();
        q_b.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_dec_count", 32'(dec_count), 0);
        @(negedge sysclk);
        rst_n = 1;
        out_ready = 1;
        repeat (4) @(posedge sysclk);
        #1;
        chk("midrst_no_output", 32'(out_valid), 0);

        chk("final_q_a_empty", 32'(q_a.size()), 0);
        chk("final_q_b_empty", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
